mem_arbiter: RTL and testbench

- Shares one single-ported, variable-latency unified memory between the instruction-fetch port and the data-memory (load/store) port of the 5-stage pipeline.
- Arbitrates between the two ports, sequences the memory req/ready/rvalid handshake, and returns responses to the winning port.
- Generates the stall signals the hazard unit ORs into its fetch and memory stalls.
- Supports dropping an in-flight fetch when a taken branch or jump redirects the PC.

---
 rtl/mem_arb_pkg.sv | 19 +
 rtl/mem_arb_prio.sv | 43 ++++
 rtl/mem_arbiter.sv | 188 ++++++++++++++++++
 tb/tb_mem_arbiter.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified-memory arbiter between the fetch and data ports.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        NONE  = 2'd0,
        FETCH = 2'd1,
        DATA  = 2'd2
    } owner_t;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_WORD = 2'd2;

endpackage

// File: rtl/mem_arb_prio.sv
// Grant decision for the two memory ports: data normally wins, but a waiting fetch
// is guaranteed a grant after MAX_DATA_STREAK back-to-back data grants.
module mem_arb_prio #(
    parameter int MAX_DATA_STREAK = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic if_req,
    input  logic dm_req,
    input  logic arb_en,
    output logic grant_if,
    output logic grant_dm
);

    localparam int SW = $clog2(MAX_DATA_STREAK + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DATA_STREAK);

    logic [SW-1:0] streak_q;
    logic [SW-1:0] streak_d;
    logic          fetch_wins;

    always_comb begin
        fetch_wins = if_req && (!dm_req || (streak_q == STREAK_MAX));
        grant_if   = arb_en && fetch_wins;
        grant_dm   = arb_en && dm_req && !fetch_wins;
        streak_d   = streak_q;
        // Only real arbitrations (some request present) move the counter.
        if (grant_if || (grant_dm && !if_req)) begin
            streak_d = '0;
        end else if (grant_dm && (streak_q != STREAK_MAX)) begin
            streak_d = streak_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            streak_q <= '0;
        end else begin
            streak_q <= streak_d;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-ported variable-latency memory between instruction fetch and
// load/store, with one outstanding transaction, fetch-drop on redirect and stall outputs.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_DATA_STREAK = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    input  logic                  if_flush,
    output logic [DATA_WIDTH-1:0] if_rdata,
    output logic                  if_valid,
    input  logic                  dm_req,
    input  logic                  dm_we,
    input  logic [1:0]            dm_size,
    input  logic [ADDR_WIDTH-1:0] dm_addr,
    input  logic [DATA_WIDTH-1:0] dm_wdata,
    output logic [DATA_WIDTH-1:0] dm_rdata,
    output logic                  dm_valid,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [1:0]            mem_size,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_ready,
    input  logic                  mem_rvalid,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  stall_if,
    output logic                  stall_dm,
    output logic [1:0]            dbg_state
);

    // Handshakes: a requester holds req and its fields until its one-cycle valid
    // pulse; mem_req is held with stable fields until the cycle mem_ready=1, and the
    // single outstanding transaction completes on the first mem_rvalid after that.

    state_t                state_q, state_d;
    owner_t                owner_q, owner_d;
    logic                  drop_q, drop_d;
    logic                  mem_req_q, mem_req_d;
    logic                  mem_we_q, mem_we_d;
    logic [1:0]            mem_size_q, mem_size_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
    logic                  if_valid_q, if_valid_d;
    logic                  dm_valid_q, dm_valid_d;
    logic [DATA_WIDTH-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_WIDTH-1:0] dm_rdata_q, dm_rdata_d;
    logic                  arb_en;
    logic                  grant_if;
    logic                  grant_dm;

    assign arb_en = (state_q == IDLE);

    mem_arb_prio #(
        .MAX_DATA_STREAK(MAX_DATA_STREAK)
    ) u_prio (
        .clk     (clk),
        .rst     (rst),
        .if_req  (if_req),
        .dm_req  (dm_req),
        .arb_en  (arb_en),
        .grant_if(grant_if),
        .grant_dm(grant_dm)
    );

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        drop_d      = drop_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_size_d  = mem_size_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_rdata_d  = if_rdata_q;
        dm_rdata_d  = dm_rdata_q;
        if_valid_d  = 1'b0;
        dm_valid_d  = 1'b0;

        case (state_q)
            IDLE: begin
                drop_d = 1'b0;
                if (grant_dm) begin
                    mem_req_d   = 1'b1;
                    mem_we_d    = dm_we;
                    mem_size_d  = dm_size;
                    mem_addr_d  = dm_addr;
                    mem_wdata_d = dm_wdata;
                    owner_d     = DATA;
                    state_d     = ISSUE;
                end else if (grant_if) begin
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_size_d  = SZ_WORD;
                    mem_addr_d  = if_addr;
                    mem_wdata_d = '0;
                    owner_d     = FETCH;
                    state_d     = ISSUE;
                end
            end

            ISSUE: begin
                if (if_flush && (owner_q == FETCH)) begin
                    drop_d = 1'b1;
                end
                if (mem_ready) begin
                    mem_req_d = 1'b0;
                    state_d   = WAIT;
                end
            end

            WAIT: begin
                if (if_flush && (owner_q == FETCH)) begin
                    drop_d = 1'b1;
                end
                if (mem_rvalid) begin
                    state_d = IDLE;
                    owner_d = NONE;
                    drop_d  = 1'b0;
                    if (owner_q == FETCH) begin
                        if_rdata_d = mem_rdata;
                        // A flush landing on the response cycle still kills it.
                        if_valid_d = !(drop_q || if_flush);
                    end else if (owner_q == DATA) begin
                        dm_valid_d = 1'b1;
                        if (!mem_we_q) begin
                            dm_rdata_d = mem_rdata;
                        end
                    end
                end
            end

            default: begin
                state_d = IDLE;
                owner_d = NONE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            owner_q     <= NONE;
            drop_q      <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_size_q  <= 2'd0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_valid_q  <= 1'b0;
            dm_valid_q  <= 1'b0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            drop_q      <= drop_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_size_q  <= mem_size_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_valid_q  <= if_valid_d;
            dm_valid_q  <= dm_valid_d;
            if_rdata_q  <= if_rdata_d;
            dm_rdata_q  <= dm_rdata_d;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_size  = mem_size_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign if_valid  = if_valid_q;
    assign dm_valid  = dm_valid_q;
    assign if_rdata  = if_rdata_q;
    assign dm_rdata  = dm_rdata_q;
    assign stall_if  = if_req & ~if_valid_q;
    assign stall_dm  = dm_req & ~dm_valid_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed and randomized checks of mem_arbiter against a transaction-level model of
// the arbitration rules, acting as both requesters and the memory.
module tb_mem_arbiter;

    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int MAXS = 4;
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd2;
    localparam logic [1:0] SZ_B    = 2'd0;
    localparam logic [1:0] SZ_W    = 2'd2;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          if_req = 1'b0;
    logic [AW-1:0] if_addr = '0;
    logic          if_flush = 1'b0;
    logic [DW-1:0] if_rdata;
    logic          if_valid;
    logic          dm_req = 1'b0;
    logic          dm_we = 1'b0;
    logic [1:0]    dm_size = 2'd0;
    logic [AW-1:0] dm_addr = '0;
    logic [DW-1:0] dm_wdata = '0;
    logic [DW-1:0] dm_rdata;
    logic          dm_valid;
    logic          mem_req;
    logic          mem_we;
    logic [1:0]    mem_size;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_ready = 1'b0;
    logic          mem_rvalid = 1'b0;
    logic [DW-1:0] mem_rdata = '0;
    logic          stall_if;
    logic          stall_dm;
    logic [1:0]    dbg_state;

    int            checks_total  = 0;
    int            checks_passed = 0;
    logic [DW-1:0] exp_q[$];
    int            model_streak  = 0;
    logic [DW-1:0] last_dm_rdata = '0;
    logic          exp_order[10];

    mem_arbiter #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_DATA_STREAK(MAXS)
    ) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
        .if_rdata(if_rdata), .if_valid(if_valid),
        .dm_req(dm_req), .dm_we(dm_we), .dm_size(dm_size), .dm_addr(dm_addr),
        .dm_wdata(dm_wdata), .dm_rdata(dm_rdata), .dm_valid(dm_valid),
        .mem_req(mem_req), .mem_we(mem_we), .mem_size(mem_size), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata), .stall_if(stall_if), .stall_dm(stall_dm),
        .dbg_state(dbg_state)
    );

    // Clock and watchdog
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", checks_passed, checks_total);
        $fatal(1, "watchdog");
    end

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_total++;
        assert (obs === exp) begin
            checks_passed++;
        end else begin
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        checks_total++;
        assert (obs === exp) begin
            checks_passed++;
        end else begin
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b0;
        if_req = 1'b0; if_flush = 1'b0; dm_req = 1'b0;
        mem_ready = 1'b0; mem_rvalid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        model_streak  = 0;
        last_dm_rdata = '0;
        @(negedge clk);
    endtask

    // Memory side of one transaction plus all output checks for it.
    // flush_mode: 0 none, 1 flush during the first WAIT cycle, 2 flush on the rvalid cycle.
    task automatic serve(input int rdy_dly, input int rv_dly, input logic [DW-1:0] rdata,
                         input logic is_fetch, input logic exp_we, input logic [1:0] exp_size,
                         input logic [AW-1:0] exp_addr, input logic [DW-1:0] exp_wdata,
                         input int flush_mode, input logic scramble);
        int   n;
        logic deliver;
        logic exp_ifv;
        logic exp_dmv;
        n = 0;
        while (mem_req !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check1("grant_timeout", mem_req, 1'b1);
        if (mem_req !== 1'b1) return;
        check1("mem_we", mem_we, exp_we);
        check32("mem_size", 32'(mem_size), 32'(exp_size));
        check32("mem_addr", mem_addr, exp_addr);
        if (exp_we) check32("mem_wdata", mem_wdata, exp_wdata);
        check1("stall_if_issue", stall_if, if_req);
        check1("stall_dm_issue", stall_dm, dm_req);
        if (scramble) begin
            if (is_fetch) begin
                if_addr = $urandom;
            end else begin
                dm_addr  = $urandom;
                dm_wdata = $urandom;
            end
        end
        for (int i = 0; i < rdy_dly; i++) begin
            @(negedge clk);
            check1("issue_hold_req", mem_req, 1'b1);
            check32("issue_hold_addr", mem_addr, exp_addr);
            check32("issue_hold_size", 32'(mem_size), 32'(exp_size));
            if (exp_we) check32("issue_hold_wdata", mem_wdata, exp_wdata);
        end
        mem_ready = 1'b1;
        @(negedge clk);
        mem_ready = 1'b0;
        check1("req_cleared", mem_req, 1'b0);
        check1("stall_if_wait", stall_if, if_req);
        check1("stall_dm_wait", stall_dm, dm_req);
        deliver = !(is_fetch && flush_mode != 0);
        for (int i = 0; i < rv_dly; i++) begin
            if (flush_mode == 1 && i == 0) if_flush = 1'b1;
            @(negedge clk);
            if_flush = 1'b0;
            check1("early_if_valid", if_valid, 1'b0);
            check1("early_dm_valid", dm_valid, 1'b0);
            check32("state_wait", 32'(dbg_state), 32'(ST_WAIT));
        end
        if (deliver) exp_q.push_back(rdata);
        mem_rvalid = 1'b1;
        mem_rdata  = rdata;
        if (flush_mode == 2) if_flush = 1'b1;
        @(negedge clk);
        mem_rvalid = 1'b0;
        if_flush   = 1'b0;
        mem_rdata  = $urandom;
        exp_ifv = is_fetch && deliver;
        exp_dmv = !is_fetch;
        check1("if_valid", if_valid, exp_ifv);
        check1("dm_valid", dm_valid, exp_dmv);
        check32("state_idle", 32'(dbg_state), 32'(ST_IDLE));
        check1("stall_if_resp", stall_if, if_req & ~exp_ifv);
        check1("stall_dm_resp", stall_dm, dm_req & ~exp_dmv);
        if (exp_ifv) begin
            check32("if_rdata", if_rdata, exp_q.pop_front());
        end else if (exp_dmv) begin
            if (exp_we) begin
                void'(exp_q.pop_front());
                check32("store_keeps_rdata", dm_rdata, last_dm_rdata);
            end else begin
                last_dm_rdata = exp_q.pop_front();
                check32("dm_rdata", dm_rdata, last_dm_rdata);
            end
        end
    endtask

    task automatic new_fetch();
        if_req  = ($urandom_range(0, 3) != 0);
        if_addr = {$urandom_range(0, 32'h0000_ffff), 2'b00} + 32'h0001_0000;
    endtask

    task automatic new_data();
        dm_req   = ($urandom_range(0, 3) != 0);
        dm_we    = 1'($urandom_range(0, 1));
        dm_size  = ($urandom_range(0, 1) != 0) ? SZ_W : SZ_B;
        dm_addr  = 32'h8000_0000 | 32'($urandom_range(0, 32'h00ff_ffff));
        dm_wdata = $urandom;
    endtask

    // Reference model: data wins unless a waiting fetch has sat through MAXS
    // consecutive data grants; the run count resets whenever fetch is not waiting.
    task automatic rand_step();
        logic fetch_first;
        int   rd;
        int   rv;
        int   fm;
        fetch_first = if_req && (!dm_req || model_streak >= MAXS);
        rd = $urandom_range(0, 3);
        rv = $urandom_range(0, 3);
        fm = $urandom_range(0, 5);
        fm = (fm == 4 && rv > 0) ? 1 : ((fm == 5) ? 2 : 0);
        if (fetch_first) begin
            model_streak = 0;
            serve(rd, rv, $urandom, 1'b1, 1'b0, SZ_W, if_addr, '0, fm, 1'b0);
            new_fetch();
        end else begin
            model_streak = if_req ? ((model_streak < MAXS) ? model_streak + 1 : MAXS) : 0;
            serve(rd, rv, $urandom, 1'b0, dm_we, dm_size, dm_addr, dm_wdata, fm,
                  1'($urandom_range(0, 1)));
            new_data();
        end
        if (!if_req && !dm_req) begin
            if ($urandom_range(0, 1) != 0) if_req = 1'b1;
            else dm_req = 1'b1;
        end
    endtask

    initial begin
        // Reset values
        #1;
        check1("rst_mem_req", mem_req, 1'b0);
        check1("rst_mem_we", mem_we, 1'b0);
        check32("rst_mem_size", 32'(mem_size), 32'd0);
        check32("rst_mem_addr", mem_addr, 32'd0);
        check32("rst_mem_wdata", mem_wdata, 32'd0);
        check1("rst_if_valid", if_valid, 1'b0);
        check1("rst_dm_valid", dm_valid, 1'b0);
        check32("rst_if_rdata", if_rdata, 32'd0);
        check32("rst_dm_rdata", dm_rdata, 32'd0);
        check32("rst_state", 32'(dbg_state), 32'(ST_IDLE));
        apply_reset();

        // Reset pulsed during WAIT, late rvalid ignored
        if_req = 1'b1; if_addr = 32'h40;
        for (int n = 0; n < 40 && mem_req !== 1'b1; n++) @(negedge clk);
        mem_ready = 1'b1;
        @(negedge clk);
        mem_ready = 1'b0;
        check32("t1_in_wait", 32'(dbg_state), 32'(ST_WAIT));
        rst = 1'b0; if_req = 1'b0;
        #1;
        check32("t1_async_state", 32'(dbg_state), 32'(ST_IDLE));
        @(negedge clk);
        rst = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678;
        @(negedge clk);
        mem_rvalid = 1'b0;
        check32("t1_state", 32'(dbg_state), 32'(ST_IDLE));
        check1("t1_if_valid", if_valid, 1'b0);
        check1("t1_dm_valid", dm_valid, 1'b0);
        check1("t1_mem_req", mem_req, 1'b0);
        @(negedge clk);
        check1("t1_if_valid_late", if_valid, 1'b0);

        // Fetch only, minimum latency
        if_req = 1'b1; if_addr = 32'h0;
        #1;
        check1("t2_stall_c0", stall_if, 1'b1);
        serve(0, 0, 32'h0050_0093, 1'b1, 1'b0, SZ_W, 32'h0, '0, 0, 1'b0);
        if_req = 1'b0;

        // Flush in IDLE has no effect on the fetch granted that cycle
        if_req = 1'b1; if_addr = 32'h80; if_flush = 1'b1;
        @(negedge clk);
        if_flush = 1'b0;
        serve(1, 1, 32'h0000_0013, 1'b1, 1'b0, SZ_W, 32'h80, '0, 0, 1'b0);
        if_req = 1'b0;

        // Simultaneous fetch and load: data first, then fetch
        if_req = 1'b1; if_addr = 32'h4;
        dm_req = 1'b1; dm_we = 1'b0; dm_size = SZ_W; dm_addr = 32'h100; dm_wdata = '0;
        serve(1, 1, 32'hDEAD_BEEF, 1'b0, 1'b0, SZ_W, 32'h100, '0, 0, 1'b0);
        dm_req = 1'b0;
        serve(0, 1, 32'h0000_0093, 1'b1, 1'b0, SZ_W, 32'h4, '0, 0, 1'b0);
        if_req = 1'b0;

        // Store with delayed ready and changing requester fields
        dm_req = 1'b1; dm_we = 1'b1; dm_size = SZ_B; dm_addr = 32'h1F3; dm_wdata = 32'hAB;
        serve(3, 1, 32'h5555_5555, 1'b0, 1'b1, SZ_B, 32'h1F3, 32'hAB, 0, 1'b1);
        dm_req = 1'b0;
        @(negedge clk);
        check1("t6_single_pulse", dm_valid, 1'b0);

        // Flush in WAIT drops the fetch; redirected fetch proceeds
        if_req = 1'b1; if_addr = 32'h300;
        serve(0, 2, 32'hBAD0_BAD0, 1'b1, 1'b0, SZ_W, 32'h300, '0, 1, 1'b0);
        if_addr = 32'h200;
        serve(0, 1, 32'h0010_0113, 1'b1, 1'b0, SZ_W, 32'h200, '0, 0, 1'b0);
        if_req = 1'b0;

        // Flush on the response cycle still drops
        if_req = 1'b1; if_addr = 32'h400;
        serve(1, 0, 32'hBAD1_BAD1, 1'b1, 1'b0, SZ_W, 32'h400, '0, 2, 1'b0);
        if_req = 1'b0;

        // Data streak limit: D,D,D,D,F,D,D,D,D,F
        apply_reset();
        exp_order = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        if_req = 1'b1; if_addr = 32'h1000;
        dm_req = 1'b1; dm_we = 1'b0; dm_size = SZ_W; dm_addr = 32'h8000_0000;
        for (int i = 0; i < 10; i++) begin
            if (exp_order[i]) begin
                serve(0, 0, $urandom, 1'b1, 1'b0, SZ_W, if_addr, '0, 0, 1'b0);
                if_addr = if_addr + 32'd4;
            end else begin
                serve(0, 0, $urandom, 1'b0, 1'b0, SZ_W, dm_addr, '0, 0, 1'b0);
                dm_addr = dm_addr + 32'd4;
            end
        end
        if_req = 1'b0; dm_req = 1'b0;

        // Randomized traffic against the model
        apply_reset();
        new_fetch();
        new_data();
        if (!if_req && !dm_req) dm_req = 1'b1;
        for (int t = 0; t < 300; t++) rand_step();
        if_req = 1'b0; dm_req = 1'b0;
        repeat (2) @(negedge clk);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
